sumres_arbiter: RTL and testbench

Controller that shares one combinational 4-bit adder/subtractor unit (the existing SumadorRestador datapath) between two requesters. It arbitrates round-robin, latches the winner's operands and op, and holds them on the unit for a programmable settle time. It then captures the sum and returns it with a signed-overflow flag and the requester ID. It sits between the lab's operand sources (switch bank / sequencer) and the shared arithmetic unit.

---
 rtl/sumres_arbiter.sv | 144 ++++++++++++++
 tb/tb_sumres_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumres_arbiter.sv
// Round-robin front end that shares one combinational 4-bit add/sub unit
// between two requesters and returns the captured result with overflow.
module sumres_arbiter #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req0_op,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic       req1_op,
   output logic       req1_ready,
   output logic [3:0] au_a,
   output logic [3:0] au_b,
   output logic       au_op,
   input  logic [3:0] au_s,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [3:0] rsp_s,
   output logic       rsp_ovf,
   output logic       busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("sumres_arbiter: SETTLE must be within 1..15");
   end

   logic [1:0] state_q, state_d;
   logic       rr_q, rr_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic       op_q, op_d;
   logic       id_q, id_d;
   logic [3:0] rsp_s_q, rsp_s_d;
   logic       rsp_ovf_q, rsp_ovf_d;
   logic       rsp_id_q, rsp_id_d;
   logic       gnt0, gnt1;
   logic       ovf;

   // Grants exist only while idle; rr_q breaks ties when both ask.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE && rst_n) begin
         gnt0 = req0_valid & (~req1_valid | ~rr_q);
         gnt1 = req1_valid & (~req0_valid | rr_q);
      end
   end

   always_comb begin
      ovf = 1'b0;
      if (au_s[3] != a_q[3]) begin
         if (op_q) ovf = (a_q[3] != b_q[3]);
         else      ovf = (a_q[3] == b_q[3]);
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      id_d      = id_q;
      rsp_s_d   = rsp_s_q;
      rsp_ovf_d = rsp_ovf_q;
      rsp_id_d  = rsp_id_q;
      unique case (state_q)
         IDLE: begin
            if (gnt0 | gnt1) begin
               a_d     = gnt1 ? req1_a  : req0_a;
               b_d     = gnt1 ? req1_b  : req0_b;
               op_d    = gnt1 ? req1_op : req0_op;
               id_d    = gnt1;
               rr_d    = ~gnt1;
               cnt_d   = 4'(SETTLE - 1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            // Capture on the last settle cycle, when cnt_q reaches zero.
            if (cnt_q == 4'd0) begin
               rsp_s_d   = au_s;
               rsp_ovf_d = ovf;
               rsp_id_d  = id_q;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_q      <= 1'b0;
         cnt_q     <= 4'd0;
         a_q       <= 4'd0;
         b_q       <= 4'd0;
         op_q      <= 1'b0;
         id_q      <= 1'b0;
         rsp_s_q   <= 4'd0;
         rsp_ovf_q <= 1'b0;
         rsp_id_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         id_q      <= id_d;
         rsp_s_q   <= rsp_s_d;
         rsp_ovf_q <= rsp_ovf_d;
         rsp_id_q  <= rsp_id_d;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign au_a       = a_q;
   assign au_b       = b_q;
   assign au_op      = op_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_s      = rsp_s_q;
   assign rsp_ovf    = rsp_ovf_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sumres_arbiter.sv
// Bench for sumres_arbiter: three instances (SETTLE 2, 1, 4) against a
// cycle model with a result scoreboard and a table of known operations.
module tb_sumres_arbiter;

   typedef struct {
      logic       id;
      logic [3:0] a;
      logic [3:0] b;
      logic       op;
      logic [3:0] s;
      logic       ovf;
   } vec_t;

   typedef struct {
      logic       id;
      logic [3:0] s;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   logic       r0v[3], r1v[3], r0op[3], r1op[3], r0r[3], r1r[3];
   logic [3:0] r0a[3], r0b[3], r1a[3], r1b[3];
   logic [3:0] au_a[3], au_b[3], rsp_s[3];
   logic       au_op[3], rsp_valid[3], rsp_id[3], rsp_ovf[3], busy[3];

   int   busy_until[3] = '{default: -1};
   int   hs_k[3]       = '{default: -10};
   logic rr_m[3]       = '{default: 1'b0};
   logic [3:0] lat_a[3] = '{default: 4'd0};
   logic [3:0] lat_b[3] = '{default: 4'd0};
   logic lat_op[3]     = '{default: 1'b0};
   logic last_id[3]    = '{default: 1'b0};
   logic [3:0] last_s[3] = '{default: 4'd0};
   logic last_ovf[3]   = '{default: 1'b0};
   logic tbl_arm[3]    = '{default: 1'b0};
   logic [3:0] tbl_s[3] = '{default: 4'd0};
   logic tbl_ovf[3]    = '{default: 1'b0};
   int   gcnt[3]       = '{default: 0};
   exp_t sbq[3][$];
   logic gq[3][$];

   int n_chk = 0;
   int n_fail = 0;
   vec_t tbl[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int st(input int u);
      return (u == 0) ? 2 : ((u == 1) ? 1 : 4);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [3:0] tru, s_m;
      // Instances 1 and 2 see garbage except on the final settle cycle.
      assign tru = au_op[g] ? au_a[g] - au_b[g] : au_a[g] + au_b[g];
      assign s_m = (g != 0 && cyc != busy_until[g] - 1) ? 4'hF : tru;
      sumres_arbiter #(.SETTLE(st(g))) dut (
         .clk(clk), .rst_n(rst_n),
         .req0_valid(r0v[g]), .req0_a(r0a[g]), .req0_b(r0b[g]),
         .req0_op(r0op[g]), .req0_ready(r0r[g]),
         .req1_valid(r1v[g]), .req1_a(r1a[g]), .req1_b(r1b[g]),
         .req1_op(r1op[g]), .req1_ready(r1r[g]),
         .au_a(au_a[g]), .au_b(au_b[g]), .au_op(au_op[g]), .au_s(s_m),
         .rsp_valid(rsp_valid[g]), .rsp_id(rsp_id[g]), .rsp_s(rsp_s[g]),
         .rsp_ovf(rsp_ovf[g]), .busy(busy[g])
      );
   end

   task automatic chk(input string nm, input int u,
                      input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s u%0d cyc %0d: got %0h expected %0h",
                  nm, u, cyc, act, exp);
      end
   endtask

   task automatic chk_zero(input int u);
      chk("rst_au_a", u, au_a[u], 4'd0);
      chk("rst_au_b", u, au_b[u], 4'd0);
      chk("rst_au_op", u, 4'(au_op[u]), 4'd0);
      chk("rst_rsp_valid", u, 4'(rsp_valid[u]), 4'd0);
      chk("rst_rsp_id", u, 4'(rsp_id[u]), 4'd0);
      chk("rst_rsp_s", u, rsp_s[u], 4'd0);
      chk("rst_rsp_ovf", u, 4'(rsp_ovf[u]), 4'd0);
      chk("rst_busy", u, 4'(busy[u]), 4'd0);
      chk("rst_ready0", u, 4'(r0r[u]), 4'd0);
      chk("rst_ready1", u, 4'(r1r[u]), 4'd0);
   endtask

   task automatic mon(input int u);
      logic e0, e1, idle, erv, id, op;
      logic [3:0] a, b;
      int r;
      exp_t e;
      idle = cyc > busy_until[u];
      e0 = idle && r0v[u] && (!r1v[u] || !rr_m[u]);
      e1 = idle && r1v[u] && (!r0v[u] || rr_m[u]);
      chk("ready0", u, 4'(r0r[u]), 4'(e0));
      chk("ready1", u, 4'(r1r[u]), 4'(e1));
      chk("busy", u, 4'(busy[u]),
          4'(cyc > hs_k[u] && cyc <= busy_until[u]));
      chk("au_a", u, au_a[u], lat_a[u]);
      chk("au_b", u, au_b[u], lat_b[u]);
      chk("au_op", u, 4'(au_op[u]), 4'(lat_op[u]));
      erv = (cyc == busy_until[u]);
      chk("rsp_valid", u, 4'(rsp_valid[u]), 4'(erv));
      if (erv) begin
         if (sbq[u].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard u%0d: got pulse expected entry", u);
         end else begin
            e = sbq[u].pop_front();
            last_id[u]  = e.id;
            last_s[u]   = e.s;
            last_ovf[u] = e.ovf;
         end
      end
      chk("rsp_id", u, 4'(rsp_id[u]), 4'(last_id[u]));
      chk("rsp_s", u, rsp_s[u], last_s[u]);
      chk("rsp_ovf", u, 4'(rsp_ovf[u]), 4'(last_ovf[u]));
      if (e0 || e1) begin
         id = e1;
         a  = id ? r1a[u] : r0a[u];
         b  = id ? r1b[u] : r0b[u];
         op = id ? r1op[u] : r0op[u];
         r  = op ? int'($signed(a)) - int'($signed(b))
                 : int'($signed(a)) + int'($signed(b));
         e.id = id;
         if (tbl_arm[u]) begin
            e.s = tbl_s[u];
            e.ovf = tbl_ovf[u];
            tbl_arm[u] = 1'b0;
         end else begin
            e.s = r[3:0];
            e.ovf = (r > 7) || (r < -8);
         end
         sbq[u].push_back(e);
         gq[u].push_back(r1r[u]);
         gcnt[u]++;
         lat_a[u] = a;
         lat_b[u] = b;
         lat_op[u] = op;
         rr_m[u] = !id;
         hs_k[u] = cyc;
         busy_until[u] = cyc + st(u) + 1;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int u = 0; u < 3; u++) begin
            if (!rst_n) begin
               busy_until[u] = -1;
               hs_k[u] = -10;
               rr_m[u] = 1'b0;
               lat_a[u] = 4'd0;
               lat_b[u] = 4'd0;
               lat_op[u] = 1'b0;
               last_id[u] = 1'b0;
               last_s[u] = 4'd0;
               last_ovf[u] = 1'b0;
               gcnt[u] = 0;
               sbq[u].delete();
               gq[u].delete();
            end else begin
               mon(u);
            end
         end
      end
   end

   task automatic wait_ready(input int u, input logic id, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (id ? r1r[u] : r0r[u]) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_idle(input int u);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (cyc > busy_until[u] && sbq[u].size() == 0) return;
      end
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout u%0d: got busy expected idle", u);
   endtask

   task automatic wait_gcnt(input int u, input int n);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (gcnt[u] >= n) return;
      end
      n_chk++;
      n_fail++;
      $display("FAIL grant_timeout u%0d: got %0d grants expected %0d",
               u, gcnt[u], n);
   endtask

   task automatic do_op(input int u, input vec_t v);
      bit ok;
      @(posedge clk);
      #1;
      tbl_s[u] = v.s;
      tbl_ovf[u] = v.ovf;
      tbl_arm[u] = 1'b1;
      if (v.id) begin
         r1a[u] = v.a; r1b[u] = v.b; r1op[u] = v.op; r1v[u] = 1'b1;
      end else begin
         r0a[u] = v.a; r0b[u] = v.b; r0op[u] = v.op; r0v[u] = 1'b1;
      end
      wait_ready(u, v.id, ok);
      @(posedge clk);
      #1;
      r0v[u] = 1'b0;
      r1v[u] = 1'b0;
      tbl_arm[u] = 1'b0;
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL handshake_timeout u%0d: got no ready expected ready", u);
      end
      wait_idle(u);
   endtask

   initial begin
      bit ok;
      vec_t v;
      tbl[0] = '{1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b1};
      tbl[1] = '{1'b0, 4'h2, 4'h5, 1'b1, 4'hD, 1'b0};
      tbl[2] = '{1'b0, 4'h8, 4'h1, 1'b1, 4'h7, 1'b1};
      tbl[3] = '{1'b1, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
      tbl[4] = '{1'b0, 4'h7, 4'h8, 1'b1, 4'hF, 1'b1};
      tbl[5] = '{1'b1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b0};
      tbl[6] = '{1'b0, 4'h5, 4'h3, 1'b1, 4'h2, 1'b0};
      tbl[7] = '{1'b1, 4'hD, 4'h4, 1'b1, 4'h9, 1'b0};
      for (int u = 0; u < 3; u++) begin
         r0v[u] = 0; r1v[u] = 0; r0op[u] = 0; r1op[u] = 0;
         r0a[u] = 0; r0b[u] = 0; r1a[u] = 0; r1b[u] = 0;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) chk_zero(u);
      rst_n = 1'b1;

      // Abandon an operation mid-EXEC.
      @(posedge clk);
      #1;
      r0a[0] = 4'h6; r0b[0] = 4'h1; r0op[0] = 1'b0; r0v[0] = 1'b1;
      wait_ready(0, 1'b0, ok);
      @(posedge clk);
      #1;
      r0v[0] = 1'b0;
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL pre_reset_grant u0: got no ready expected ready");
      end
      chk("exec_busy", 0, 4'(busy[0]), 4'd1);
      #2;
      rst_n = 1'b0;
      #1;
      for (int u = 0; u < 3; u++) chk_zero(u);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Contention: 3+2 from req0 must win first, then strict alternation.
      r0a[0] = 4'h3; r0b[0] = 4'h2; r0op[0] = 1'b0; r0v[0] = 1'b1;
      r1a[0] = 4'h4; r1b[0] = 4'hE; r1op[0] = 1'b1; r1v[0] = 1'b1;
      wait_gcnt(0, 8);
      @(posedge clk);
      #1;
      r0v[0] = 1'b0;
      r1v[0] = 1'b0;
      wait_idle(0);
      chk("contend_count", 0, 4'(gq[0].size()), 4'd8);
      for (int i = 0; i < gq[0].size(); i++)
         chk("contend_order", 0, 4'(gq[0][i]), 4'(i % 2));

      // Lone requester 1 is served back to back.
      gq[0].delete();
      gcnt[0] = 0;
      @(posedge clk);
      #1;
      r1a[0] = 4'h7; r1b[0] = 4'h1; r1op[0] = 1'b0; r1v[0] = 1'b1;
      wait_gcnt(0, 3);
      @(posedge clk);
      #1;
      r1v[0] = 1'b0;
      wait_idle(0);
      chk("lone_count", 0, 4'(gq[0].size()), 4'd3);
      for (int i = 0; i < gq[0].size(); i++)
         chk("lone_id", 0, 4'(gq[0][i]), 4'd1);

      // A lone grant to 0 must still hand priority to 1.
      v = '{1'b0, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0};
      do_op(0, v);
      gq[0].delete();
      gcnt[0] = 0;
      @(posedge clk);
      #1;
      r0a[0] = 4'h1; r0b[0] = 4'h2; r0op[0] = 1'b0; r0v[0] = 1'b1;
      r1a[0] = 4'h6; r1b[0] = 4'h2; r1op[0] = 1'b1; r1v[0] = 1'b1;
      wait_gcnt(0, 1);
      @(posedge clk);
      #1;
      r0v[0] = 1'b0;
      r1v[0] = 1'b0;
      wait_idle(0);
      if (gq[0].size() > 0) chk("rr_toggle", 0, 4'(gq[0][0]), 4'd1);
      else chk("rr_toggle_count", 0, 4'(gq[0].size()), 4'd1);

      // Known vectors on every SETTLE variant.
      for (int u = 0; u < 3; u++)
         for (int i = 0; i < 8; i++) do_op(u, tbl[i]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
